ram_sync: RTL and testbench

Parametrised synchronous single-port data memory, the clocked successor to the combinational `ram` block. It provides registered reads with configurable latency, byte-enable writes, out-of-range address detection, and a hardware zero-initialisation sweep after reset. It sits on the datapath memory stage and is driven by the same `Readmem`/`Writemem` strobes as the existing memory.

---
 rtl/ram_sync.sv | 133 +++++++++++++
 tb/tb_ram_sync.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync.sv
// Synchronous single-port data memory with registered reads (latency 1 or 2),
// byte-enable writes, out-of-range detection and a zeroing sweep after reset.
module ram_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int READ_LAT   = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   adress,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    Readmem,
  input  logic                    Writemem,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    addr_err,
  output logic                    busy
);

  localparam int NumBytes = DATA_WIDTH / 8;
  localparam int IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IdxW-1:0]     LastIdx  = IdxW'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       cnt_q;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  inRange_d;
  logic                  accept_d;
  logic                  acceptRd_d;
  logic                  memWe_d;
  logic [IdxW-1:0]       memIdx_d;
  logic [NumBytes-1:0]   memMask_d;
  logic [DATA_WIDTH-1:0] memWdata_d;

  logic                  rdValid_q;
  logic                  rdErr_q;
  logic [DATA_WIDTH-1:0] rdData_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == INIT) begin
      if (cnt_q == LastIdx) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The sweep and normal writes share one write port; they never overlap in time.
  always_comb begin
    inRange_d  = {1'b0, adress} < DepthExt;
    accept_d   = (state_q == IDLE) && (Readmem || Writemem);
    acceptRd_d = accept_d && Readmem;
    memWe_d    = 1'b0;
    memIdx_d   = adress[IdxW-1:0];
    memMask_d  = byte_en;
    memWdata_d = data_in;
    if (!reset) begin
      if (state_q == INIT) begin
        memWe_d    = 1'b1;
        memIdx_d   = cnt_q;
        memMask_d  = '1;
        memWdata_d = '0;
      end else begin
        memWe_d = accept_d && Writemem && inRange_d;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (memWe_d) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (memMask_d[i]) mem[memIdx_d][8*i +: 8] <= memWdata_d[8*i +: 8];
      end
    end
  end

  // First read stage samples the pre-write word, giving read-before-write.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rdValid_q <= 1'b0;
      rdErr_q   <= 1'b0;
      rdData_q  <= '0;
    end else begin
      rdValid_q <= acceptRd_d;
      rdErr_q   <= accept_d && !inRange_d;
      if (acceptRd_d) rdData_q <= inRange_d ? mem[adress[IdxW-1:0]] : '0;
    end
  end

  generate
    if (READ_LAT == 2) begin : gLat2
      logic                  outValid_q;
      logic                  outErr_q;
      logic [DATA_WIDTH-1:0] outData_q;

      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          outValid_q <= 1'b0;
          outErr_q   <= 1'b0;
          outData_q  <= '0;
        end else begin
          outValid_q <= rdValid_q;
          outErr_q   <= rdErr_q;
          if (rdValid_q) outData_q <= rdData_q;
        end
      end

      assign data_out   = outData_q;
      assign data_valid = outValid_q;
      assign addr_err   = outErr_q;
    end else begin : gLat1
      assign data_out   = rdData_q;
      assign data_valid = rdValid_q;
      assign addr_err   = rdErr_q;
    end
  endgenerate

  assign busy = busy_q;

endmodule

// File: tb/tb_ram_sync.sv
// Bench for ram_sync: one instance per read latency, shared stimulus, and a
// timestamped reference model predicting every output after every edge.
module tb_ram_sync;

  localparam int Depth   = 16;
  localparam int HistLen = 4096;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic        reset = 1'b1;
  logic [31:0] adress = '0;
  logic [31:0] dataIn = '0;
  logic [3:0]  byteEn = '0;
  logic        readMem = 1'b0;
  logic        writeMem = 1'b0;

  logic [1:0][31:0] dOut;
  logic [1:0]       dv;
  logic [1:0]       ae;
  logic [1:0]       bsy;

  int errors = 0;
  int checks = 0;

  ram_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(Depth), .READ_LAT(1)) uLat1 (
    .CLOCK_50(CLOCK_50), .reset(reset), .adress(adress), .data_in(dataIn),
    .byte_en(byteEn), .Readmem(readMem), .Writemem(writeMem),
    .data_out(dOut[0]), .data_valid(dv[0]), .addr_err(ae[0]), .busy(bsy[0])
  );

  ram_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(Depth), .READ_LAT(2)) uLat2 (
    .CLOCK_50(CLOCK_50), .reset(reset), .adress(adress), .data_in(dataIn),
    .byte_en(byteEn), .Readmem(readMem), .Writemem(writeMem),
    .data_out(dOut[1]), .data_valid(dv[1]), .addr_err(ae[1]), .busy(bsy[1])
  );

  // Reference model: memory contents, sweep progress, and per-edge read results
  // which become visible (latency-1) edges later on each instance.
  bit [31:0]        refMem [Depth];
  bit               refBusy = 1'b1;
  int               sweepCnt = 0;
  int               edgeN = 0;
  bit               histV [HistLen];
  bit               histE [HistLen];
  bit [31:0]        histD [HistLen];
  bit [1:0]         expV;
  bit [1:0]         expE;
  bit [1:0][31:0]   lastD = '0;

  task automatic setIdle();
    reset    = 1'b0;
    readMem  = 1'b0;
    writeMem = 1'b0;
  endtask

  task automatic tick();
    int  idx;
    int  j;
    bit  inR;
    edgeN++;
    idx = edgeN % HistLen;
    histV[idx] = 1'b0;
    histE[idx] = 1'b0;
    histD[idx] = '0;
    if (reset) begin
      refBusy = 1'b1;
      sweepCnt = 0;
      histV[(edgeN - 1) % HistLen] = 1'b0;
      histE[(edgeN - 1) % HistLen] = 1'b0;
      lastD = '0;
    end else if (refBusy) begin
      refMem[sweepCnt] = '0;
      sweepCnt++;
      if (sweepCnt == Depth) refBusy = 1'b0;
    end else if (readMem || writeMem) begin
      inR = adress < 32'(Depth);
      if (readMem) begin
        histV[idx] = 1'b1;
        histD[idx] = inR ? refMem[adress[3:0]] : 32'h0;
      end
      histE[idx] = !inR;
      if (writeMem && inR) begin
        for (int b = 0; b < 4; b++)
          if (byteEn[b]) refMem[adress[3:0]][8*b +: 8] = dataIn[8*b +: 8];
      end
    end
    @(posedge CLOCK_50);
    #1;
    for (int k = 0; k < 2; k++) begin
      j = (edgeN - k) % HistLen;
      expV[k] = histV[j];
      expE[k] = histE[j];
      if (histV[j]) lastD[k] = histD[j];
    end
  endtask

  task automatic test_reset();
    int busyCnt = 0;
    reset = 1'b1;
    readMem = 1'b0;
    writeMem = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bsy[k], dv[k], ae[k], dOut[k]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("[TB] FAIL reset_state lat%0d: got busy=%b v=%b e=%b d=%h, want busy=1 v=0 e=0 d=0",
                 k + 1, bsy[k], dv[k], ae[k], dOut[k]);
      end
    end
    setIdle();
    for (int c = 0; c < 20; c++) begin
      if (bsy[0] === 1'b1) busyCnt++;
      tick();
    end
    checks++;
    if (busyCnt !== 16) begin
      errors++;
      $display("[TB] FAIL sweep_length: got busy cycles=%0d, want 16", busyCnt);
    end
    for (int a = 0; a <= Depth; a++) begin
      readMem = (a < Depth);
      adress  = 32'(a % Depth);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({bsy[k], dv[k], ae[k], dOut[k]} !== {refBusy, expV[k], expE[k], 32'h0}) begin
          errors++;
          $display("[TB] FAIL sweep_zero lat%0d edge%0d: got busy=%b v=%b e=%b d=%h, want busy=%b v=%b e=%b d=0",
                   k + 1, edgeN, bsy[k], dv[k], ae[k], dOut[k], refBusy, expV[k], expE[k]);
        end
      end
    end
    setIdle();
  endtask

  task automatic test_write_read();
    setIdle();
    writeMem = 1'b1; adress = 32'd3; dataIn = 32'hDEADBEEF; byteEn = 4'hF;
    tick();
    writeMem = 1'b0; readMem = 1'b1;
    tick();
    readMem = 1'b0;
    checks++;
    if ({dv, dOut[0]} !== {2'b01, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL latency_edge1: got v=%b d1=%h, want v=01 d1=deadbeef", dv, dOut[0]);
    end
    tick();
    checks++;
    if ({dv, dOut[1]} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL latency_edge2: got v=%b d2=%h, want v=10 d2=deadbeef", dv, dOut[1]);
    end
    tick();
    checks++;
    if ({dv, dOut[0], dOut[1]} !== {2'b00, 32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL latency_hold: got v=%b d1=%h d2=%h, want v=00 both deadbeef", dv, dOut[0], dOut[1]);
    end
  endtask

  task automatic test_byte_enable();
    setIdle();
    writeMem = 1'b1; adress = 32'd3; dataIn = 32'h11223344; byteEn = 4'b0101;
    tick();
    writeMem = 1'b0; readMem = 1'b1;
    tick();
    readMem = 1'b0;
    checks++;
    if ({dv[0], dOut[0]} !== {1'b1, 32'hDE22BE44}) begin
      errors++;
      $display("[TB] FAIL byte_en_lat1: got v=%b d=%h, want v=1 d=de22be44", dv[0], dOut[0]);
    end
    tick();
    checks++;
    if ({dv[1], dOut[1]} !== {1'b1, 32'hDE22BE44}) begin
      errors++;
      $display("[TB] FAIL byte_en_lat2: got v=%b d=%h, want v=1 d=de22be44", dv[1], dOut[1]);
    end
  endtask

  task automatic test_read_during_write();
    setIdle();
    writeMem = 1'b1; adress = 32'd5; dataIn = 32'h1; byteEn = 4'hF;
    tick();
    readMem = 1'b1; dataIn = 32'h2;
    tick();
    writeMem = 1'b0;
    checks++;
    if ({dv[0], dOut[0]} !== {1'b1, 32'h1}) begin
      errors++;
      $display("[TB] FAIL rbw_old_lat1: got v=%b d=%h, want v=1 d=00000001", dv[0], dOut[0]);
    end
    tick();
    readMem = 1'b0;
    checks++;
    if ({dv, dOut[0], dOut[1]} !== {2'b11, 32'h2, 32'h1}) begin
      errors++;
      $display("[TB] FAIL rbw_new: got v=%b d1=%h d2=%h, want v=11 d1=2 d2=1", dv, dOut[0], dOut[1]);
    end
    tick();
    checks++;
    if ({dv, dOut[1]} !== {2'b10, 32'h2}) begin
      errors++;
      $display("[TB] FAIL rbw_new_lat2: got v=%b d2=%h, want v=10 d2=2", dv, dOut[1]);
    end
  endtask

  task automatic test_back_to_back();
    int validCnt [2] = '{0, 0};
    int firstAt [2] = '{-1, -1};
    int lastAt [2] = '{-1, -1};
    setIdle();
    byteEn = 4'hF;
    for (int a = 0; a < 4; a++) begin
      writeMem = 1'b1; adress = 32'(a); dataIn = $urandom;
      tick();
    end
    writeMem = 1'b0;
    for (int c = 0; c < 7; c++) begin
      readMem = (c < 4);
      adress  = 32'(c);
      tick();
      for (int k = 0; k < 2; k++) begin
        if (dv[k] === 1'b1) begin
          validCnt[k]++;
          if (firstAt[k] < 0) firstAt[k] = c;
          lastAt[k] = c;
        end
        checks++;
        if ({dv[k], ae[k], dOut[k]} !== {expV[k], expE[k], lastD[k]}) begin
          errors++;
          $display("[TB] FAIL b2b_data lat%0d edge%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   k + 1, edgeN, dv[k], ae[k], dOut[k], expV[k], expE[k], lastD[k]);
        end
      end
    end
    readMem = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (validCnt[k] != 4 || lastAt[k] - firstAt[k] != 3 || firstAt[k] != k) begin
        errors++;
        $display("[TB] FAIL b2b_pulses lat%0d: got count=%0d first=%0d last=%0d, want count=4 first=%0d last=%0d",
                 k + 1, validCnt[k], firstAt[k], lastAt[k], k, k + 3);
      end
    end
  endtask

  task automatic test_out_of_range();
    int errCnt [2] = '{0, 0};
    bit [8:0] ops [8] = '{9'h0_10, 9'h1_10, 9'h0_FF, 9'h0_FE, 9'h0_FE, 9'h1_00, 9'h0_FE, 9'h0_FE};
    setIdle();
    writeMem = 1'b1; adress = 32'd0; dataIn = 32'hA5A5A5A5; byteEn = 4'hF;
    tick();
    dataIn = 32'hFFFFFFFF;
    for (int c = 0; c < 8; c++) begin
      readMem  = ops[c][8];
      writeMem = !ops[c][8] && ops[c][7:0] != 8'hFE;
      adress   = (ops[c][7:0] == 8'hFF) ? 32'h1000_0000 : 32'(ops[c][7:0]);
      tick();
      for (int k = 0; k < 2; k++) begin
        if (ae[k] === 1'b1) errCnt[k]++;
        checks++;
        if ({dv[k], ae[k], dOut[k]} !== {expV[k], expE[k], lastD[k]}) begin
          errors++;
          $display("[TB] FAIL oor_cycle lat%0d edge%0d: got v=%b e=%b d=%h, want v=%b e=%b d=%h",
                   k + 1, edgeN, dv[k], ae[k], dOut[k], expV[k], expE[k], lastD[k]);
        end
      end
      if (c == 1) begin
        checks++;
        if ({dv[0], ae[0], dOut[0]} !== {1'b1, 1'b1, 32'h0}) begin
          errors++;
          $display("[TB] FAIL oor_read: got v=%b e=%b d=%h, want v=1 e=1 d=0", dv[0], ae[0], dOut[0]);
        end
      end
    end
    setIdle();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (errCnt[k] != 3) begin
        errors++;
        $display("[TB] FAIL oor_err_pulses lat%0d: got %0d, want 3", k + 1, errCnt[k]);
      end
    end
    checks++;
    if (dOut[1] !== 32'hA5A5A5A5) begin
      errors++;
      $display("[TB] FAIL oor_mem0: got %h, want a5a5a5a5", dOut[1]);
    end
  endtask

  task automatic test_random();
    int r;
    setIdle();
    for (int c = 0; c < 300; c++) begin
      readMem  = $urandom_range(0, 1);
      writeMem = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r == 0)      adress = $urandom | 32'h0001_0000;
      else if (r == 1) adress = 32'($urandom_range(16, 20));
      else             adress = 32'($urandom_range(0, 15));
      dataIn = $urandom;
      byteEn = 4'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({bsy[k], dv[k], ae[k], dOut[k]} !== {refBusy, expV[k], expE[k], lastD[k]}) begin
          errors++;
          $display("[TB] FAIL random lat%0d edge%0d: got busy=%b v=%b e=%b d=%h, want busy=%b v=%b e=%b d=%h",
                   k + 1, edgeN, bsy[k], dv[k], ae[k], dOut[k], refBusy, expV[k], expE[k], lastD[k]);
        end
      end
    end
    setIdle();
  endtask

  task automatic test_reset_mid_sweep();
    int busyCnt = 0;
    reset = 1'b1;
    tick();
    setIdle();
    for (int c = 0; c < 7; c++) tick();
    reset = 1'b1;
    tick();
    setIdle();
    for (int c = 0; c < 20; c++) begin
      if (bsy[0] === 1'b1) busyCnt++;
      tick();
      checks++;
      if (bsy !== {refBusy, refBusy}) begin
        errors++;
        $display("[TB] FAIL restart_busy edge%0d: got %b, want %b", edgeN, bsy, {refBusy, refBusy});
      end
    end
    checks++;
    if (busyCnt !== 16) begin
      errors++;
      $display("[TB] FAIL restart_length: got busy cycles=%0d, want 16", busyCnt);
    end
  endtask

  task automatic test_reset_mid_read();
    setIdle();
    writeMem = 1'b1; adress = 32'd2; dataIn = 32'hCAFE0002; byteEn = 4'hF;
    tick();
    writeMem = 1'b0; readMem = 1'b1;
    tick();
    readMem = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if ({dv, ae, dOut[1]} !== {2'b00, 2'b00, 32'h0}) begin
      errors++;
      $display("[TB] FAIL midread_reset: got v=%b e=%b d2=%h, want v=00 e=00 d2=0", dv, ae, dOut[1]);
    end
    setIdle();
    tick();
    checks++;
    if (dv !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midread_after: got v=%b, want 00", dv);
    end
  endtask

  task automatic test_busy_strobes();
    int pulses = 0;
    setIdle();
    while (refBusy) begin
      readMem  = 1'b1;
      writeMem = 1'b1;
      adress   = 32'($urandom_range(0, 20));
      dataIn   = 32'hFFFFFFFF;
      byteEn   = 4'hF;
      tick();
      if (dv !== 2'b00 || ae !== 2'b00) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL busy_pulses: got %0d cycles with pulses, want 0", pulses);
    end
    for (int a = 0; a <= Depth; a++) begin
      readMem  = (a < Depth);
      writeMem = 1'b0;
      adress   = 32'(a % Depth);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({dv[k], ae[k], dOut[k]} !== {expV[k], expE[k], 32'h0}) begin
          errors++;
          $display("[TB] FAIL busy_no_write lat%0d edge%0d: got v=%b e=%b d=%h, want v=%b e=%b d=0",
                   k + 1, edgeN, dv[k], ae[k], dOut[k], expV[k], expE[k]);
        end
      end
    end
    setIdle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_read_during_write();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_mid_sweep();
    test_random();
    test_reset_mid_read();
    test_busy_strobes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
